pixel_binarizer: RTL and testbench
==================================

PIXEL_BINARIZER -- requirements
Module: pixel_binarizer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CH, 3: bytes per pixel, legal 1..4.
- ADDR_W, 18: source byte-address width.
- DST_AW, 16: destination word-address width.
- PACK_W, 8: result bits per destination word, legal 1..32.
- RD_LAT, 2: source read latency in cycles, legal 1..15.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: sole clock, rising edge. One clock; reset is asynchronous and active-low.
- rst_n, in, 1: asynchronous active-low reset.
- width, in, 16: image width in pixels, sampled at start.
- height, in, 16: image height in pixels, sampled at start.
- thr, in, CH*8: per-channel threshold; byte c belongs to channel c; sampled at start.
- mode, in, 2: bit0 selects 0=all-below or 1=any-below; bit1 inverts the result; sampled at start.
- start, in, 1: level request to begin.
- abort, in, 1: cancel the job.
- busy, out, 1: a job is active.
- done, out, 1: the job has finished.
- err, out, 1: the size check failed.
- src_addr, out, ADDR_W: source RAM byte address.
- src_we, out, 1: source RAM write enable.
- src_din, out, 8: source RAM write data.
- src_dout, in, 8: source RAM read data.
- host_addr, in, ADDR_W: host-side source address.
- host_we, in, 1: host-side source write enable.
- host_din, in, 8: host-side source write data.
- dst_we, out, 1: destination write pulse.
- dst_addr, out, DST_AW: destination word address.
- dst_din, out, PACK_W: packed result word.

Function
REQ-003 State machine has six states: IDLE, CHK, RD, WAIT, CMP and DONE.
REQ-004 IDLE exits to CHK when start=1; all configuration inputs are latched on that edge.
REQ-005 CHK takes one cycle and computes N=width*height in 32 bits.
- N=0 goes to DONE with err=0 and no writes.
- N*CH>2^ADDR_W goes to DONE with err=1 and no writes.
- Otherwise it goes to RD with pixel index p=0 and channel c=0.
REQ-006 RD drives src_addr=p*CH+c for one cycle, then enters WAIT.
REQ-007 WAIT lasts RD_LAT cycles; on its last cycle src_dout is captured as channel c.
- If c<CH-1, c increments and the FSM returns to RD.
- Otherwise the FSM goes to CMP.
REQ-008 Channel c is "below" when its byte is strictly less than thr byte c (unsigned compare).
REQ-009 The result bit is computed from the below flags.
- mode[0]=0: bit = AND over the CH below flags.
- mode[0]=1: bit = OR over the CH below flags.
- mode[1]=1: the bit is then inverted.
REQ-010 In CMP the result bit is stored at position p mod PACK_W of the pack register (LSB first).
- If the word is complete or p=N-1, the next cycle drives dst_we=1, dst_addr=p/PACK_W, dst_din=pack register.
- Unused upper bits of a partial final word are 0.
- The pack register then clears.
REQ-011 After CMP, p increments and the FSM returns to RD with c=0; after the last pixel it goes to DONE.
REQ-012 Every pixel costs exactly CH*(RD_LAT+1)+1 cycles; dst_we for a word overlaps the next pixel's RD cycle.
REQ-013 dst_we is a single-cycle pulse and is issued exactly ceil(N/PACK_W) times per successful job.
REQ-014 busy=1 in states CHK through CMP.
REQ-015 done=1 and err hold in DONE until start=0; the FSM then returns to IDLE, clearing done and err.
REQ-016 The source port is multiplexed by state.
- While busy=0, src_addr, src_we and src_din follow host_addr, host_we and host_din through one register stage.
- While busy=1, src_we=0 and src_din=0.
REQ-017 abort=1 in any non-IDLE state forces IDLE on the next edge.
- No further dst_we is issued, done is not asserted, and the pack register clears.
- abort takes priority over start and over normal transitions.
REQ-018 start is ignored outside IDLE; thr, mode, width and height changes during a job have no effect.

Reset
REQ-019 rst_n=0 immediately forces the following, independent of clk: state=IDLE, p=0, c=0, pack register=0, busy=0, done=0, err=0, dst_we=0, dst_addr=0, dst_din=0, src_addr=0, src_we=0, src_din=0.
REQ-020 Reset mid-job discards the partial word; the first edge after release samples start normally.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- width=4, height=2, CH=3, thr=0x111111, mode=0, all pixels 0x101010 except pixel 5=0x201010 -> one dst_we at addr 0 with din=0xDF; done one cycle after; total 8*(3*3+1)+2 cycles from start.
- Same image with mode=1 -> din=0xFF; with mode=2 -> din=0x20.
- width=3, height=3, PACK_W=8 -> two writes: addr 0 full word, addr 1 with bits[7:1]=0.
- width=0 -> done=1 and err=0 within 2 cycles, no dst_we; width=height=512, CH=3, ADDR_W=18 -> err=1, no dst_we.
- abort asserted during WAIT of pixel 3 -> IDLE next cycle, no dst_we, done stays 0; a new start then produces a correct full job.
- busy=0 with host_we=1, host_addr=0x155, host_din=0xA5 -> src_we=1, src_addr=0x155, src_din=0xA5 one cycle later; rst_n pulsed low mid-job -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pixel_binarizer.sv
// Thresholds a CH-byte-per-pixel image held in an external source RAM and
// packs one result bit per pixel into PACK_W-bit destination words.
module pixel_binarizer #(
    parameter int CH     = 3,
    parameter int ADDR_W = 18,
    parameter int DST_AW = 16,
    parameter int PACK_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         width,
    input  logic [15:0]         height,
    input  logic [CH*8-1:0]     thr,
    input  logic [1:0]          mode,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   src_addr,
    output logic                src_we,
    output logic [7:0]          src_din,
    input  logic [7:0]          src_dout,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic                host_we,
    input  logic [7:0]          host_din,
    output logic                dst_we,
    output logic [DST_AW-1:0]   dst_addr,
    output logic [PACK_W-1:0]   dst_din
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_RD, S_WAIT, S_CMP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         width_q, width_d, height_q, height_d;
    logic [CH*8-1:0]     thr_q, thr_d;
    logic [1:0]          mode_q, mode_d;
    logic [31:0]         last_q, last_d;
    logic [31:0]         p_q, p_d;
    logic [1:0]          c_q, c_d;
    logic [3:0]          w_q, w_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [CH-1:0][7:0]  px_q, px_d;
    logic [PACK_W-1:0]   pack_q, pack_d;
    logic [4:0]          bpos_q, bpos_d;
    logic [DST_AW-1:0]   waddr_q, waddr_d;
    logic                done_q, done_d, err_q, err_d;
    logic                dst_we_q, dst_we_d;
    logic [DST_AW-1:0]   dst_addr_q, dst_addr_d;
    logic [PACK_W-1:0]   dst_din_q, dst_din_d;
    logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
    logic                src_we_q, src_we_d;
    logic [7:0]          src_din_q, src_din_d;

    logic [31:0]         prod;
    logic [39:0]         nch;
    logic [39:0]         lim;
    logic [CH-1:0]       below;
    logic                res;
    logic                last_w;
    logic                busy_d;
    logic [PACK_W-1:0]   pack_n;

    always_comb begin
        prod = width_q * height_q;
        nch  = 40'(prod) * 40'(CH);
        lim  = 40'd1 << ADDR_W;
        for (int k = 0; k < CH; k++) begin
            below[k] = px_q[k] < thr_q[k*8 +: 8];
        end
        res    = (mode_q[0] ? |below : &below) ^ mode_q[1];
        last_w = (w_q == 4'(RD_LAT - 1));
        pack_n = pack_q | (PACK_W'(res) << bpos_q);
    end

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        thr_d      = thr_q;
        mode_d     = mode_q;
        last_d     = last_q;
        p_d        = p_q;
        c_d        = c_q;
        w_d        = w_q;
        a_d        = a_q;
        px_d       = px_q;
        pack_d     = pack_q;
        bpos_d     = bpos_q;
        waddr_d    = waddr_q;
        err_d      = err_q;
        dst_we_d   = 1'b0;
        dst_addr_d = dst_addr_q;
        dst_din_d  = dst_din_q;
        src_addr_d = src_addr_q;
        src_we_d   = 1'b0;
        src_din_d  = 8'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d  = width;
                    height_d = height;
                    thr_d    = thr;
                    mode_d   = mode;
                    state_d  = S_CHK;
                end
            end
            S_CHK: begin
                last_d  = prod - 32'd1;
                p_d     = 32'd0;
                c_d     = 2'd0;
                w_d     = 4'd0;
                a_d     = '0;
                pack_d  = '0;
                bpos_d  = 5'd0;
                waddr_d = '0;
                if (prod == 32'd0) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (nch > lim) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                w_d     = 4'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (last_w) begin
                    for (int k = 0; k < CH; k++) begin
                        if (int'(c_q) == k) px_d[k] = src_dout;
                    end
                    a_d = a_q + ADDR_W'(1);
                    if (int'(c_q) == CH - 1) begin
                        state_d = S_CMP;
                    end else begin
                        c_d     = c_q + 2'd1;
                        state_d = S_RD;
                    end
                end else begin
                    w_d = w_q + 4'd1;
                end
            end
            S_CMP: begin
                // Flush on a full word or on the last pixel; the write lands in
                // the next pixel's RD cycle.
                if (bpos_q == 5'(PACK_W - 1) || p_q == last_q) begin
                    dst_we_d   = 1'b1;
                    dst_addr_d = waddr_q;
                    dst_din_d  = pack_n;
                    pack_d     = '0;
                    bpos_d     = 5'd0;
                    waddr_d    = waddr_q + DST_AW'(1);
                end else begin
                    pack_d = pack_n;
                    bpos_d = bpos_q + 5'd1;
                end
                c_d = 2'd0;
                if (p_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    p_d     = p_q + 32'd1;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            dst_we_d = 1'b0;
            pack_d   = '0;
            bpos_d   = 5'd0;
            waddr_d  = '0;
            p_d      = 32'd0;
            c_d      = 2'd0;
        end

        done_d = (state_d == S_DONE) && (state_q == S_DONE);
        if (state_d == S_IDLE) err_d = 1'b0;

        busy_d = (state_d == S_CHK) || (state_d == S_RD) ||
                 (state_d == S_WAIT) || (state_d == S_CMP);
        if (!busy_d) begin
            src_addr_d = host_addr;
            src_we_d   = host_we;
            src_din_d  = host_din;
        end else if (state_d == S_RD) begin
            src_addr_d = a_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            thr_q      <= '0;
            mode_q     <= '0;
            last_q     <= '0;
            p_q        <= '0;
            c_q        <= '0;
            w_q        <= '0;
            a_q        <= '0;
            px_q       <= '0;
            pack_q     <= '0;
            bpos_q     <= '0;
            waddr_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dst_we_q   <= 1'b0;
            dst_addr_q <= '0;
            dst_din_q  <= '0;
            src_addr_q <= '0;
            src_we_q   <= 1'b0;
            src_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            thr_q      <= thr_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            p_q        <= p_d;
            c_q        <= c_d;
            w_q        <= w_d;
            a_q        <= a_d;
            px_q       <= px_d;
            pack_q     <= pack_d;
            bpos_q     <= bpos_d;
            waddr_q    <= waddr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dst_we_q   <= dst_we_d;
            dst_addr_q <= dst_addr_d;
            dst_din_q  <= dst_din_d;
            src_addr_q <= src_addr_d;
            src_we_q   <= src_we_d;
            src_din_q  <= src_din_d;
        end
    end

    assign busy     = (state_q == S_CHK) || (state_q == S_RD) ||
                      (state_q == S_WAIT) || (state_q == S_CMP);
    assign done     = done_q;
    assign err      = err_q;
    assign dst_we   = dst_we_q;
    assign dst_addr = dst_addr_q;
    assign dst_din  = dst_din_q;
    assign src_addr = src_addr_q;
    assign src_we   = src_we_q;
    assign src_din  = src_din_q;

endmodule

// File: tb/tb_pixel_binarizer.sv
// Directed bench for pixel_binarizer: external source RAM model with a
// two-cycle read pipeline, image loaded through the host port.
module tb_pixel_binarizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] width = '0, height = '0;
    logic [23:0] thr = '0;
    logic [1:0]  mode = '0;
    logic        start = 1'b0, abort = 1'b0;
    logic        busy, done, err;
    logic [17:0] src_addr;
    logic        src_we;
    logic [7:0]  src_din, src_dout;
    logic [17:0] host_addr = '0;
    logic        host_we = 1'b0;
    logic [7:0]  host_din = '0;
    logic        dst_we;
    logic [15:0] dst_addr;
    logic [7:0]  dst_din;

    int errors = 0;
    int checks = 0;

    pixel_binarizer dut (
        .clk(clk), .rst_n(rst_n), .width(width), .height(height), .thr(thr),
        .mode(mode), .start(start), .abort(abort), .busy(busy), .done(done),
        .err(err), .src_addr(src_addr), .src_we(src_we), .src_din(src_din),
        .src_dout(src_dout), .host_addr(host_addr), .host_we(host_we),
        .host_din(host_din), .dst_we(dst_we), .dst_addr(dst_addr),
        .dst_din(dst_din)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    logic [7:0] rp0, rp1;
    always @(posedge clk) begin
        if (src_we) mem[src_addr[7:0]] <= src_din;
        rp0 <= mem[src_addr[7:0]];
        rp1 <= rp0;
    end
    assign src_dout = rp1;

    // Observations of the most recent run_job
    int         n_we;
    int         we_cyc [0:7];
    logic [15:0] we_addr [0:7];
    logic [7:0] we_din [0:7];
    int         done_cyc;
    logic       busy0;
    logic       err_at_done;

    task automatic host_write(input logic [17:0] a, input logic [7:0] d);
        host_addr = a; host_din = d; host_we = 1'b1;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    task automatic load_image();
        for (int p = 0; p < 9; p++)
            for (int c = 0; c < 3; c++)
                host_write(18'(p*3 + c), (p == 5 && c == 2) ? 8'h20 : 8'h10);
        @(posedge clk); #1;
    endtask

    // Cycle numbers count edges after the edge that samples start.
    task automatic run_job(input logic [15:0] w, input logic [15:0] h,
                           input logic [1:0] md, input int budget);
        width = w; height = h; mode = md; thr = 24'h111111; start = 1'b1;
        n_we = 0; done_cyc = -1; err_at_done = 1'b0;
        @(posedge clk); #1;
        busy0 = busy;
        width = 16'd7; height = 16'd7; thr = 24'h000000; mode = 2'd3;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            if (dst_we) begin
                if (n_we < 8) begin
                    we_cyc[n_we] = cyc; we_addr[n_we] = dst_addr; we_din[n_we] = dst_din;
                end
                n_we++;
            end
            if (done) begin
                done_cyc = cyc; err_at_done = err;
                break;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({busy, done, err, dst_we, src_we} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=00000", {busy, done, err, dst_we, src_we}); end
        checks++; if ({src_addr, src_din, dst_addr, dst_din} !== '0) begin
            errors++; $display("FAIL reset_buses got src_addr=%h src_din=%h dst_addr=%h dst_din=%h want 0",
                               src_addr, src_din, dst_addr, dst_din); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_host_passthrough();
        host_addr = 18'h155; host_din = 8'hA5; host_we = 1'b1;
        @(posedge clk); #1;
        host_we = 1'b0;
        checks++; if ({src_we, src_addr, src_din} !== {1'b1, 18'h155, 8'hA5}) begin
            errors++; $display("FAIL host_pass got we=%b addr=%h din=%h want 1 155 a5", src_we, src_addr, src_din); end
        @(posedge clk); #1;
        checks++; if (src_we !== 1'b0) begin
            errors++; $display("FAIL host_pass_we_drop got=%b want=0", src_we); end
    endtask

    task automatic test_mode_and();
        run_job(16'd4, 16'd2, 2'd0, 200);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL and_busy got=%b want=1", busy0); end
        checks++; if (n_we !== 1) begin errors++; $display("FAIL and_nwe got=%0d want=1", n_we); end
        checks++; if ({we_addr[0], we_din[0]} !== {16'h0, 8'hDF}) begin
            errors++; $display("FAIL and_word got addr=%h din=%h want 0 df", we_addr[0], we_din[0]); end
        checks++; if (we_cyc[0] !== 81) begin errors++; $display("FAIL and_we_cycle got=%0d want=81", we_cyc[0]); end
        checks++; if (done_cyc !== 82) begin errors++; $display("FAIL and_done_cycle got=%0d want=82", done_cyc); end
        checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL and_err got=%b want=0", err_at_done); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL and_done_clear got=%b want=00", {done, err}); end
    endtask

    task automatic test_mode_or();
        run_job(16'd4, 16'd2, 2'd1, 200);
        checks++; if (n_we !== 1 || we_din[0] !== 8'hFF) begin
            errors++; $display("FAIL or_word got n=%0d din=%h want 1 ff", n_we, we_din[0]); end
    endtask

    task automatic test_mode_inv();
        run_job(16'd4, 16'd2, 2'd2, 200);
        checks++; if (n_we !== 1 || we_din[0] !== 8'h20) begin
            errors++; $display("FAIL inv_word got n=%0d din=%h want 1 20", n_we, we_din[0]); end
    endtask

    task automatic test_partial_word();
        run_job(16'd3, 16'd3, 2'd0, 200);
        checks++; if (n_we !== 2) begin errors++; $display("FAIL part_nwe got=%0d want=2", n_we); end
        checks++; if ({we_addr[0], we_din[0]} !== {16'h0, 8'hDF}) begin
            errors++; $display("FAIL part_word0 got addr=%h din=%h want 0 df", we_addr[0], we_din[0]); end
        checks++; if ({we_addr[1], we_din[1]} !== {16'h1, 8'h01}) begin
            errors++; $display("FAIL part_word1 got addr=%h din=%h want 1 01", we_addr[1], we_din[1]); end
        checks++; if (done_cyc !== 92) begin errors++; $display("FAIL part_done_cycle got=%0d want=92", done_cyc); end
    endtask

    task automatic test_zero_size();
        run_job(16'd0, 16'd5, 2'd0, 20);
        checks++; if (done_cyc < 1 || done_cyc > 2) begin
            errors++; $display("FAIL zero_done_cycle got=%0d want 1..2", done_cyc); end
        checks++; if (err_at_done !== 1'b0 || n_we !== 0) begin
            errors++; $display("FAIL zero_result got err=%b nwe=%0d want 0 0", err_at_done, n_we); end
    endtask

    task automatic test_oversize();
        run_job(16'd512, 16'd512, 2'd0, 20);
        checks++; if (done_cyc < 1 || done_cyc > 2) begin
            errors++; $display("FAIL big_done_cycle got=%0d want 1..2", done_cyc); end
        checks++; if (err_at_done !== 1'b1 || n_we !== 0) begin
            errors++; $display("FAIL big_result got err=%b nwe=%0d want 1 0", err_at_done, n_we); end
    endtask

    task automatic test_abort();
        int seen_we = 0;
        int seen_done = 0;
        width = 16'd4; height = 16'd2; mode = 2'd0; thr = 24'h111111; start = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(posedge clk); #1;
            if (dst_we) seen_we++;
        end
        abort = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b want=0", busy); end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (dst_we) seen_we++;
            if (done) seen_done++;
            @(posedge clk); #1;
        end
        checks++; if (seen_we !== 0 || seen_done !== 0) begin
            errors++; $display("FAIL abort_quiet got we=%0d done=%0d want 0 0", seen_we, seen_done); end
        run_job(16'd4, 16'd2, 2'd2, 200);
        checks++; if (n_we !== 1 || we_din[0] !== 8'h20 || done_cyc !== 82) begin
            errors++; $display("FAIL abort_rerun got n=%0d din=%h done=%0d want 1 20 82", n_we, we_din[0], done_cyc); end
    endtask

    task automatic test_async_reset();
        width = 16'd4; height = 16'd2; mode = 2'd0; thr = 24'h111111; start = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin @(posedge clk); #1; end
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, err, dst_we, src_we} !== 5'b0) begin
            errors++; $display("FAIL areset_flags got=%b want=00000", {busy, done, err, dst_we, src_we}); end
        checks++; if ({src_addr, src_din, dst_addr, dst_din} !== '0) begin
            errors++; $display("FAIL areset_buses got src_addr=%h src_din=%h dst_addr=%h dst_din=%h want 0",
                               src_addr, src_din, dst_addr, dst_din); end
        @(posedge clk); #1; rst_n = 1'b1;
        run_job(16'd4, 16'd2, 2'd1, 200);
        checks++; if (n_we !== 1 || we_din[0] !== 8'hFF || done_cyc !== 82) begin
            errors++; $display("FAIL areset_rerun got n=%0d din=%h done=%0d want 1 ff 82", n_we, we_din[0], done_cyc); end
    endtask

    initial begin
        test_reset();
        test_host_passthrough();
        load_image();
        test_mode_and();
        test_mode_or();
        test_mode_inv();
        test_partial_word();
        test_zero_size();
        test_oversize();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
